// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare of the ID source registers against the EX load destination.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic       memread_ex,
  input  logic [4:0] dst_ex,
  output logic       load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = use_rs1_id && (rs1_id == dst_ex);
  assign rs2_hit_s = use_rs2_id && (rs2_id == dst_ex);
  // x0 is never a real producer, so a load targeting it cannot create a hazard
  assign load_use  = memread_ex && (dst_ex != REG_X0) && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with data-memory wait timeout.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             memread_ex,
  input  logic [4:0]       dst_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int            CW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_e        state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          bus_err_r, bus_err_next_s;
  logic          load_use_s, mem_busy_s;
  logic          pc_stall_s, ifid_stall_s, ifid_flush_s;
  logic          idex_stall_s, idex_flush_s, exmem_stall_s, memwb_flush_s;

  load_use_detect u_load_use_detect (
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .memread_ex (memread_ex),
    .dst_ex     (dst_ex),
    .load_use   (load_use_s)
  );

  assign mem_busy_s = dmem_req_mem && !dmem_ready;

  // Next-state and stall/flush decode; priority ERR > memory wait > branch > load-use
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    bus_err_next_s = bus_err_r;
    pc_stall_s     = 1'b0;
    ifid_stall_s   = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_stall_s   = 1'b0;
    idex_flush_s   = 1'b0;
    exmem_stall_s  = 1'b0;
    memwb_flush_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_busy_s) begin
          {pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s, memwb_flush_s} = 5'b11111;
          state_next_s = ST_MEMWAIT;
          cnt_next_s   = ONE_C;
        end else if (branch_taken_ex) begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          cnt_next_s   = '0;
        end else if (load_use_s) begin
          pc_stall_s   = 1'b1;
          ifid_stall_s = 1'b1;
          idex_flush_s = 1'b1;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = '0;
        end
      end
      ST_MEMWAIT: begin
        if (!dmem_ready) begin
          {pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s, memwb_flush_s} = 5'b11111;
          if (cnt_r == TIMEOUT_C) begin
            state_next_s   = ST_ERR;
            bus_err_next_s = 1'b1;
          end else begin
            cnt_next_s = cnt_r + ONE_C;
          end
        end else begin
          // Memory completes this cycle; the rest of the pipeline is judged as in RUN
          state_next_s = ST_RUN;
          cnt_next_s   = '0;
          if (branch_taken_ex) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            pc_stall_s   = 1'b1;
            ifid_stall_s = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            pc_stall_s = 1'b0;
          end
        end
      end
      ST_ERR: begin
        {pc_stall_s, ifid_stall_s, idex_stall_s, exmem_stall_s, memwb_flush_s} = 5'b11111;
      end
      default: begin
        state_next_s = ST_RUN;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, timeout counter and sticky error register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= ST_RUN;
      cnt_r     <= '0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bus_err_r <= bus_err_next_s;
    end
  end

  // Outputs are forced low for the whole reset cycle, before state has been cleared
  assign pc_stall    = rstn && pc_stall_s;
  assign ifid_stall  = rstn && ifid_stall_s;
  assign ifid_flush  = rstn && ifid_flush_s;
  assign idex_stall  = rstn && idex_stall_s;
  assign idex_flush  = rstn && idex_flush_s;
  assign exmem_stall = rstn && exmem_stall_s;
  assign memwb_flush = rstn && memwb_flush_s;
  assign bus_err     = rstn && bus_err_r;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating perf counters; ifid_flush is raised only by a branch redirect
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (pc_stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ifid_flush_s && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = rstn ? stall_cnt_r : '0;
  assign flush_events = rstn ? flush_cnt_r : '0;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;
  // Output vector: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush bus_err
  localparam logic [7:0] P_NONE = 8'b0000_0000;
  localparam logic [7:0] P_LU   = 8'b1100_1000;
  localparam logic [7:0] P_BR   = 8'b0010_1000;
  localparam logic [7:0] P_MW   = 8'b1101_0110;
  localparam logic [7:0] P_ERR  = 8'b1101_0111;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] rs1_id, rs2_id, dst_ex;
  logic use_rs1_id, use_rs2_id, memread_ex, branch_taken_ex, dmem_req_mem, dmem_ready;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, bus_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [7:0] obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .memread_ex(memread_ex), .dst_ex(dst_ex), .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .bus_err(bus_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, bus_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic mr, input logic [4:0] dst, input logic br,
                       input logic req, input logic rdy);
    rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
    memread_ex = mr; dst_ex = dst; branch_taken_ex = br;
    dmem_req_mem = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    // load-use inputs active during reset must not leak to the outputs
    drive(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL reset_outputs got %b expected %b", obs, P_NONE); fails++;
    end
    tests++;
    if (stall_cycles !== '0 || flush_events !== '0) begin
      $display("FAIL reset_counters got %0d/%0d expected 0/0", stall_cycles, flush_events); fails++;
    end
    rstn = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    drive(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_LU) begin
      $display("FAIL load_use_rs1 got %b expected %b", obs, P_LU); fails++;
    end
    tick();
    // load has moved to MEM, bubble now in EX
    drive(5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL load_use_release got %b expected %b", obs, P_NONE); fails++;
    end
    tick();
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (obs !== P_MW) begin
        $display("FAIL memwait_cycle%0d got %b expected %b", i, obs, P_MW); fails++;
      end
      tick();
    end
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL memwait_ready got %b expected %b", obs, P_NONE); fails++;
    end
    tick();
    // in MEMWAIT a low ready would stall even without a request; RUN does not
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL memwait_back_to_run got %b expected %b", obs, P_NONE); fails++;
    end
    tick();
  endtask

  task automatic test_perf(input int exp_stall_en, input int exp_flush_en, input string tag);
    logic [CNT_W-1:0] es, ef;
`ifdef PIPE_PERF_CNT_EN
    es = CNT_W'(exp_stall_en); ef = CNT_W'(exp_flush_en);
`else
    es = '0; ef = '0;
`endif
    tests++;
    if (stall_cycles !== es) begin
      $display("FAIL %s_stall_cycles got %0d expected %0d", tag, stall_cycles, es); fails++;
    end
    tests++;
    if (flush_events !== ef) begin
      $display("FAIL %s_flush_events got %0d expected %0d", tag, flush_events, ef); fails++;
    end
  endtask

  task automatic test_operand_filter();
    drive(5'd0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL x0_exempt got %b expected %b", obs, P_NONE); fails++;
    end
    drive(5'd1, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL rs2_unused got %b expected %b", obs, P_NONE); fails++;
    end
    drive(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL not_a_load got %b expected %b", obs, P_NONE); fails++;
    end
    drive(5'd1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_LU) begin
      $display("FAIL load_use_rs2 got %b expected %b", obs, P_LU); fails++;
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_branch();
    drive(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tests++;
    if (obs !== P_BR) begin
      $display("FAIL branch_over_load_use got %b expected %b", obs, P_BR); fails++;
    end
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (obs !== P_BR) begin
      $display("FAIL branch_only got %b expected %b", obs, P_BR); fails++;
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_ready_branch();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tests++;
    if (obs !== P_MW) begin
      $display("FAIL memwait_beats_branch got %b expected %b", obs, P_MW); fails++;
    end
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    tests++;
    if (obs !== P_BR) begin
      $display("FAIL ready_with_branch got %b expected %b", obs, P_BR); fails++;
    end
    tick();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1);
    tests++;
    if (obs !== P_LU) begin
      $display("FAIL ready_with_load_use got %b expected %b", obs, P_LU); fails++;
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      exp = (i < 5) ? P_MW : P_ERR;
      tests++;
      if (obs !== exp) begin
        $display("FAIL timeout_cycle%0d got %b expected %b", i, obs, exp); fails++;
      end
      tick();
    end
    // ERR ignores a late ready and a branch
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    tests++;
    if (obs !== P_ERR) begin
      $display("FAIL err_sticky got %b expected %b", obs, P_ERR); fails++;
    end
    tick();
    rstn = 1'b0;
    #1;
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL err_during_reset got %b expected %b", obs, P_NONE); fails++;
    end
    tick();
    rstn = 1'b1;
    idle();
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL err_after_reset got %b expected %b", obs, P_NONE); fails++;
    end
    drive(5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== P_LU) begin
      $display("FAIL run_after_reset got %b expected %b", obs, P_LU); fails++;
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    // no request and no ready: MEMWAIT would still stall, RUN must not
    idle();
    tests++;
    if (obs !== P_NONE) begin
      $display("FAIL reset_mid_memwait got %b expected %b", obs, P_NONE); fails++;
    end
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_memwait();
    test_perf(4, 0, "perf_seq1");
    test_operand_filter();
    test_branch();
    test_ready_branch();
    test_perf(9, 3, "perf_seq2");
    test_timeout();
    test_perf(1, 0, "perf_after_reset");
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
